// File: rtl/serial_pattern_tx_if.sv
// Load handshake and serial output bundle for serial_pattern_tx.
// The master modport is the pattern source; the slave modport is the transmitter.
interface serial_pattern_tx_if;
   logic [7:0] pat_data;
   logic [2:0] pat_len;
   logic [3:0] rep_cnt;
   logic       load_valid;
   logic       load_ready;
   logic       abort;
   logic       tx_bit;
   logic       tx_valid;
   logic       busy;
   logic       done;

   modport master (
      output pat_data, pat_len, rep_cnt, load_valid, abort,
      input  load_ready, tx_bit, tx_valid, busy, done
   );

   modport slave (
      input  pat_data, pat_len, rep_cnt, load_valid, abort,
      output load_ready, tx_bit, tx_valid, busy, done
   );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serialises a 1..8 bit pattern MSB-first, repeated 1..16 times with optional idle gaps
// between passes, and pulses done for one cycle on normal completion.
module serial_pattern_tx #(
   parameter bit          IDLE_LEVEL = 1'b1,
   parameter int unsigned GAP_CYCLES = 2
) (
   input logic               clk,
   input logic               reset,
   serial_pattern_tx_if.slave bus
);

   localparam bit       GapEn   = (GAP_CYCLES != 0);
   localparam logic [3:0] GapLoad = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] pat_q, pat_d;
   logic [2:0] len_q, len_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] rep_q, rep_d;
   logic [3:0] gap_q, gap_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pat_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      case (state_q)
         StIdle: begin
            if (bus.load_valid && !bus.abort) begin
               pat_d   = bus.pat_data;
               len_d   = bus.pat_len;
               idx_d   = bus.pat_len;
               rep_d   = bus.rep_cnt;
               state_d = StShift;
            end
         end
         StShift: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (idx_q != 3'd0) begin
               idx_d = idx_q - 3'd1;
            end else if (rep_q == 4'd0) begin
               state_d = StDone;
            end else begin
               rep_d   = rep_q - 4'd1;
               idx_d   = len_q;
               gap_d   = GapLoad;
               state_d = GapEn ? StGap : StShift;
            end
         end
         StGap: begin
            // gap_q counts GAP_CYCLES-1 down to 0, giving exactly GAP_CYCLES idle cycles
            if (bus.abort) begin
               state_d = StIdle;
            end else if (gap_q == 4'd0) begin
               state_d = StShift;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   logic load_ready, tx_bit, tx_valid, busy, done;

   always_comb begin
      load_ready = 1'b0;
      tx_bit     = IDLE_LEVEL;
      tx_valid   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         // reset is the only input reaching an output: ready must drop while it is held
         StIdle:  load_ready = !reset;
         StShift: begin
            tx_bit   = pat_q[idx_q];
            tx_valid = 1'b1;
            busy     = 1'b1;
         end
         StGap:   busy = 1'b1;
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   assign bus.load_ready = load_ready;
   assign bus.tx_bit     = tx_bit;
   assign bus.tx_valid   = tx_valid;
   assign bus.busy       = busy;
   assign bus.done       = done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one instance with a 2-cycle gap and one with no gap, driven
// in lockstep and compared every cycle against a schedule-based reference model.
module tb_serial_pattern_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       lv;
   logic       ab;
   logic [7:0] data;
   logic [2:0] len;
   logic [3:0] rep;

   always #5 clk = ~clk;

   serial_pattern_tx_if bus2();
   serial_pattern_tx_if bus0();

   assign bus2.pat_data   = data;
   assign bus2.pat_len    = len;
   assign bus2.rep_cnt    = rep;
   assign bus2.load_valid = lv;
   assign bus2.abort      = ab;
   assign bus0.pat_data   = data;
   assign bus0.pat_len    = len;
   assign bus0.rep_cnt    = rep;
   assign bus0.load_valid = lv;
   assign bus0.abort      = ab;

   serial_pattern_tx #(.IDLE_LEVEL(1'b1), .GAP_CYCLES(2)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   serial_pattern_tx #(.IDLE_LEVEL(1'b1), .GAP_CYCLES(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: index 0 mirrors the GAP=2 instance, index 1 the GAP=0 instance.
   // k is the cycle number since the accepting edge (1 = first pattern bit).
   bit         act_m [2];
   int         k_m   [2];
   logic [7:0] md    [2];
   int         ml    [2];
   int         mr    [2];

   function automatic int gap_of(input int m);
      return (m == 0) ? 2 : 0;
   endfunction

   function automatic int total_of(input int m);
      return (ml[m] + 1) * (mr[m] + 1) + gap_of(m) * mr[m];
   endfunction

   // {tx_bit, tx_valid, busy, done}
   function automatic logic [3:0] model_out(input int m);
      int period;
      int pos;
      logic [7:0] p;
      if (!act_m[m]) return 4'b1000;
      if (k_m[m] > total_of(m)) return 4'b1001;
      period = ml[m] + 1 + gap_of(m);
      pos    = (k_m[m] - 1) % period;
      p      = md[m];
      if (pos <= ml[m]) return {p[ml[m] - pos], 3'b110};
      return 4'b1010;
   endfunction

   task automatic model_step(input int m);
      if (reset) begin
         act_m[m] = 1'b0;
      end else if (act_m[m]) begin
         if (ab) act_m[m] = 1'b0;
         else begin
            k_m[m]++;
            if (k_m[m] > total_of(m) + 1) act_m[m] = 1'b0;
         end
      end else if (lv && !ab) begin
         act_m[m] = 1'b1;
         k_m[m]   = 1;
         md[m]    = data;
         ml[m]    = int'(len);
         mr[m]    = int'(rep);
      end
   endtask

   task automatic tick(input logic rst_v, input logic lv_v, input logic ab_v,
                       input logic [7:0] d_v, input logic [2:0] l_v, input logic [3:0] r_v);
      reset = rst_v;
      lv    = lv_v;
      ab    = ab_v;
      data  = d_v;
      len   = l_v;
      rep   = r_v;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      chk("gap2 outputs", {4'b0, bus2.tx_bit, bus2.tx_valid, bus2.busy, bus2.done}, {4'b0, model_out(0)});
      chk("gap2 load_ready", {7'b0, bus2.load_ready}, {7'b0, !act_m[0] && !reset});
      chk("gap0 outputs", {4'b0, bus0.tx_bit, bus0.tx_valid, bus0.busy, bus0.done}, {4'b0, model_out(1)});
      chk("gap0 load_ready", {7'b0, bus0.load_ready}, {7'b0, !act_m[1] && !reset});
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0);
   endtask

   typedef struct {
      logic       rst, lv, ab;
      logic [7:0] data;
      logic [2:0] len;
      logic [3:0] rep;
      logic       e_bit, e_valid, e_busy, e_done, e_ready;
   } vec_t;

   vec_t vecs [13];

   logic [17:0] eb;
   logic [17:0] ev;

   initial begin
      // single pass 8'h02/len 3, load attempt during DONE, then abort on the third bit of 8'hA5
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h02, 3'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 3'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 3'd7, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 8'hFF, 3'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      act_m[0] = 1'b0;
      act_m[1] = 1'b0;
      reset = 1'b1;
      lv    = 1'b0;
      ab    = 1'b0;
      data  = 8'h00;
      len   = 3'd0;
      rep   = 4'd0;

      for (int i = 0; i < 13; i++) begin
         tick(vecs[i].rst, vecs[i].lv, vecs[i].ab, vecs[i].data, vecs[i].len, vecs[i].rep);
         chk($sformatf("vec%0d outputs", i),
             {4'b0, bus2.tx_bit, bus2.tx_valid, bus2.busy, bus2.done},
             {4'b0, vecs[i].e_bit, vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_done});
         chk($sformatf("vec%0d load_ready", i), {7'b0, bus2.load_ready}, {7'b0, vecs[i].e_ready});
      end

      // 8'hA5 twice with a 2-cycle gap; an 8'hFF load in cycle 5 must be ignored
      eb = 18'b10100101_11_10100101;
      ev = 18'b11111111_00_11111111;
      tick(1'b0, 1'b1, 1'b0, 8'hA5, 3'd7, 4'd1);
      for (int c = 1; c <= 19; c++) begin
         if (c > 1) begin
            if (c == 5) tick(1'b0, 1'b1, 1'b0, 8'hFF, 3'd0, 4'd0);
            else idle_ticks(1);
         end
         if (c <= 18) begin
            chk($sformatf("repeat c%0d tx_bit", c), {7'b0, bus2.tx_bit}, {7'b0, eb[18 - c]});
            chk($sformatf("repeat c%0d tx_valid", c), {7'b0, bus2.tx_valid}, {7'b0, ev[18 - c]});
         end else begin
            chk("repeat done", {7'b0, bus2.done}, 8'd1);
         end
      end
      idle_ticks(1);
      chk("repeat ready after done", {7'b0, bus2.load_ready}, 8'd1);
      idle_ticks(3);

      // 1-bit pattern, 16 passes, no gap
      tick(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 4'd15);
      for (int c = 1; c <= 17; c++) begin
         if (c > 1) idle_ticks(1);
         if (c <= 16)
            chk($sformatf("nogap c%0d bit/valid", c), {6'b0, bus0.tx_bit, bus0.tx_valid}, 8'd1);
         else
            chk("nogap done", {7'b0, bus0.done}, 8'd1);
      end
      idle_ticks(40);

      // reset in the second gap cycle truncates the transfer
      tick(1'b0, 1'b1, 1'b0, 8'hA5, 3'd7, 4'd1);
      idle_ticks(9);
      chk("gap2 in gap", {6'b0, bus2.tx_valid, bus2.busy}, 8'd1);
      tick(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0);
      chk("reset mid-gap", {4'b0, bus2.load_ready, bus2.tx_bit, bus2.tx_valid, bus2.busy}, 8'b0100);
      for (int i = 0; i < 20; i++) begin
         idle_ticks(1);
         chk("no resume after reset", {6'b0, bus2.tx_valid, bus2.done}, 8'd0);
      end

      for (int i = 0; i < 3000; i++) begin
         tick(($urandom % 100) == 0, ($urandom % 4) == 0, ($urandom % 40) == 0,
              8'($urandom), 3'($urandom), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
